mc_control_fsm: RTL
===================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port opcode, input, 6 bits: instruction[31:26] taken from the instruction register.
REQ-004 The block SHALL have port mem_ready, input, 1 bit: memory access completes in the current cycle.
REQ-005 The block SHALL have outputs IorD, MemRead, MemWrite, IRWrite, PCWrite, Branch, ALUSrcA, regDst, MemtoReg and regWrite, each 1 bit, datapath strobes and selects.
REQ-006 The block SHALL have outputs PCSrc, ALUSrcB and ALUOp, each 2 bits: PCSrc 00 ALU, 01 ALUOut, 10 jump target; ALUSrcB 00 reg, 01 const 4, 10 signext, 11 signext<<2; ALUOp 00 add, 01 sub, 10 funct.
REQ-007 The block SHALL have output illegal_op, 1 bit: one-cycle pulse on an unsupported opcode.
REQ-008 The block SHALL have output state_dbg, 4 bits: current state encoding.

Function
REQ-009 The block SHALL implement these states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, ADDIEXE, ADDIWB, BEQ, JUMP.
REQ-010 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00 and PCSrc=00.
REQ-011 FETCH SHALL assert IRWrite and PCWrite only in the cycle with mem_ready=1, then go to DECODE; with mem_ready=0 it SHALL hold in FETCH.
REQ-012 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11 and ALUOp=00 (branch target into ALUOut).
REQ-013 DECODE SHALL branch on opcode: 100011/101011 to MEMADR, 000000 to RTEXE, 001000 to ADDIEXE, 000100 to BEQ, 000010 to JUMP.
REQ-014 On any other opcode, DECODE SHALL pulse illegal_op and go to FETCH.
REQ-015 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp=00, then go to MEMRD if opcode=100011, else MEMWR.
REQ-016 MEMRD SHALL drive MemRead=1 and IorD=1, holding until mem_ready=1, then go to MEMWB.
REQ-017 MEMWB SHALL drive regWrite=1, MemtoReg=1 and regDst=0, then go to FETCH.
REQ-018 MEMWR SHALL drive MemWrite=1 and IorD=1, holding until mem_ready=1, then go to FETCH.
REQ-019 RTEXE SHALL drive ALUSrcA=1, ALUSrcB=00 and ALUOp=10; RTWB SHALL drive regWrite=1, regDst=1 and MemtoReg=0.
REQ-020 ADDIEXE SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp=00; ADDIWB SHALL drive regWrite=1, regDst=0 and MemtoReg=0.
REQ-021 BEQ SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1 and PCSrc=01; JUMP SHALL drive PCWrite=1 and PCSrc=10; both SHALL then go to FETCH.
REQ-022 Every output not listed for a state SHALL be 0.
REQ-023 Outputs SHALL be combinational from state, plus mem_ready qualification in FETCH only.
REQ-024 Cycle counts with mem_ready held high SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-025 opcode SHALL be sampled only in DECODE and MEMADR; it is stable from IRWrite onward.

Reset
REQ-026 When rst=1 at a clock edge, state SHALL become FETCH regardless of the current state, including mid-stall.
REQ-027 While in reset and in the first FETCH cycle, MemWrite, regWrite, IRWrite, PCWrite and illegal_op SHALL be 0, except FETCH qualification per REQ-011 once rst=0.
REQ-028 A reset asserted during MEMWR SHALL deassert MemWrite in the next cycle, with no partial writeback state retained.

Structure
REQ-029 Package mc_ctrl_pkg SHALL hold the state enum, the opcode constants (R, LW, SW, ADDI, BEQ, J) and the ALUOp, PCSrc and ALUSrcB codes.
REQ-030 Sub-module mc_ctrl_decode SHALL provide a purely combinational mapping from state and mem_ready to the control vector.
REQ-031 The top level SHALL contain the state register and next-state logic only.

Verification
REQ-032 lw with mem_ready=1: rst, then opcode=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regWrite=1 and MemtoReg=1 in cycle 5 only.
REQ-033 sw with mem_ready low for 3 cycles in MEMWR: MemWrite=1 for 4 cycles, then FETCH; regWrite never 1.
REQ-034 FETCH stall of 2 cycles: IRWrite and PCWrite=0 for 2 cycles, then 1 for exactly 1 cycle.
REQ-035 opcode=111111 -> illegal_op=1 for 1 cycle in DECODE, FETCH next, no write strobes.
REQ-036 beq, then j: beq shows Branch=1, ALUOp=01, PCSrc=01; j shows PCWrite=1, PCSrc=10; each takes 3 cycles.
REQ-037 rst=1 while stalled in MEMRD -> FETCH next cycle, all strobes 0 during reset.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM:
// state enum, opcode constants, datapath select codes and the control vector.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXE   = 4'd6,
    S_RTWB    = 4'd7,
    S_ADDIEXE = 4'd8,
    S_ADDIWB  = 4'd9,
    S_BEQ     = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG      = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_SEXT     = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       alu_src_a;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] pc_src;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J};
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Instruction/memory status inputs and datapath control outputs of the FSM.
interface mc_control_fsm_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic       Branch;
  logic       ALUSrcA;
  logic       regDst;
  logic       MemtoReg;
  logic       regWrite;
  logic [1:0] PCSrc;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       illegal_op;
  logic [3:0] state_dbg;

  modport master (
    output opcode, mem_ready,
    input  IorD, MemRead, MemWrite, IRWrite, PCWrite, Branch, ALUSrcA,
           regDst, MemtoReg, regWrite, PCSrc, ALUSrcB, ALUOp,
           illegal_op, state_dbg
  );

  modport slave (
    input  opcode, mem_ready,
    output IorD, MemRead, MemWrite, IRWrite, PCWrite, Branch, ALUSrcA,
           regDst, MemtoReg, regWrite, PCSrc, ALUSrcB, ALUOp,
           illegal_op, state_dbg
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational state-to-control mapping; mem_ready only qualifies the
// instruction-register and PC updates in FETCH.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_SEXT_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_SEXT;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_RTEXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.branch    = 1'b1;
        ctrl.pc_src    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM: state register, next-state logic and
// the illegal-opcode pulse; control decode lives in mc_ctrl_decode.
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input logic             clk,
  input logic             rst,
  mc_control_fsm_if.slave bus
);

  state_t state_q, state_d;
  ctrl_t  ctrl;
  logic   illegal;
  logic   run;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_RTEXE;
          OP_ADDI:      state_d = S_ADDIEXE;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
        illegal = !is_legal(bus.opcode);
      end
      S_MEMADR:  state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (bus.mem_ready) state_d = S_FETCH;
      S_RTEXE:   state_d = S_RTWB;
      S_ADDIEXE: state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  // Strobes are held off while rst is high so an interrupted access
  // (e.g. a stalled store) cannot fire during the reset cycle.
  assign run = !rst;

  assign bus.IorD       = ctrl.iord;
  assign bus.MemRead    = ctrl.mem_read  & run;
  assign bus.MemWrite   = ctrl.mem_write & run;
  assign bus.IRWrite    = ctrl.ir_write  & run;
  assign bus.PCWrite    = ctrl.pc_write  & run;
  assign bus.Branch     = ctrl.branch    & run;
  assign bus.ALUSrcA    = ctrl.alu_src_a;
  assign bus.regDst     = ctrl.reg_dst;
  assign bus.MemtoReg   = ctrl.mem_to_reg;
  assign bus.regWrite   = ctrl.reg_write & run;
  assign bus.PCSrc      = ctrl.pc_src;
  assign bus.ALUSrcB    = ctrl.alu_src_b;
  assign bus.ALUOp      = ctrl.alu_op;
  assign bus.illegal_op = illegal & run;
  assign bus.state_dbg  = state_q;

endmodule
